// File: rtl/pmem_loader.sv
// pmem_loader: loads the AVR program RAM from a framed UART byte stream.
// Frame: 0x55, LEN_LO, LEN_HI, LEN little-endian words, optional CK byte.
// Optional feature macro: PMEM_LOADER_CKSUM_EN (expects and verifies the CK byte).
// The core is held in reset while a frame is being loaded.

module pmem_loader #(
    parameter int          ADDR_W  = 10,
    parameter logic [23:0] TIMEOUT = 24'd1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_wa,
    output logic [15:0]       mem_wd,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DAT_LO,
        S_DAT_HI,
`ifdef PMEM_LOADER_CKSUM_EN
        S_CKSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;
    localparam logic [7:0]  SYNC     = 8'h55;

    state_t              r_state, w_stateNxt;
    logic [15:0]         r_len, w_lenNxt;
    logic [7:0]          r_lo, w_loNxt;
    logic [ADDR_W:0]     r_wcnt, w_wcntNxt;
    logic [23:0]         r_tcnt, w_tcntNxt;
    logic                r_we, w_weNxt;
    logic [ADDR_W-1:0]   r_wa, w_waNxt;
    logic [15:0]         r_wd, w_wdNxt;
    logic                r_hold, w_holdNxt;
    logic                r_done, w_doneNxt;
    logic                r_err, w_errNxt;
`ifdef PMEM_LOADER_CKSUM_EN
    logic [7:0]          r_cksum, w_cksumNxt;
`endif

    logic [15:0]         w_lenFull;
    logic [ADDR_W:0]     w_wcntInc;
    logic                w_inFrame;

    assign w_lenFull = {rx_data, r_len[7:0]};
    assign w_wcntInc = r_wcnt + 1'b1;
    assign w_inFrame = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);

    // Frame parser: next-state, word assembly, write strobe and status flags.
    always_comb begin
        w_stateNxt = r_state;
        w_lenNxt   = r_len;
        w_loNxt    = r_lo;
        w_wcntNxt  = r_wcnt;
        w_tcntNxt  = r_tcnt;
        w_weNxt    = 1'b0;
        w_waNxt    = r_wa;
        w_wdNxt    = r_wd;
        w_holdNxt  = r_hold;
        w_doneNxt  = r_done;
        w_errNxt   = r_err;
`ifdef PMEM_LOADER_CKSUM_EN
        w_cksumNxt = r_cksum;
`endif

        if (rx_valid) begin
            w_tcntNxt = 24'd0;
        end else if (w_inFrame) begin
            w_tcntNxt = r_tcnt + 24'd1;
        end

        if (rx_valid) begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (rx_data == SYNC) begin
                        w_stateNxt = S_LEN_LO;
                        w_holdNxt  = 1'b1;
                        w_doneNxt  = 1'b0;
                        w_errNxt   = 1'b0;
                        w_wcntNxt  = '0;
                        w_waNxt    = '0;
`ifdef PMEM_LOADER_CKSUM_EN
                        w_cksumNxt = 8'd0;
`endif
                    end
                end
                S_LEN_LO: begin
                    w_lenNxt   = {8'd0, rx_data};
                    w_stateNxt = S_LEN_HI;
`ifdef PMEM_LOADER_CKSUM_EN
                    w_cksumNxt = r_cksum + rx_data;
`endif
                end
                S_LEN_HI: begin
                    w_lenNxt = w_lenFull;
`ifdef PMEM_LOADER_CKSUM_EN
                    w_cksumNxt = r_cksum + rx_data;
`endif
                    if ({1'b0, w_lenFull} > CAPACITY) begin
                        w_stateNxt = S_ERR;
                        w_errNxt   = 1'b1;
                    end else if (w_lenFull == 16'd0) begin
`ifdef PMEM_LOADER_CKSUM_EN
                        w_stateNxt = S_CKSUM;
`else
                        w_stateNxt = S_DONE;
                        w_doneNxt  = 1'b1;
                        w_holdNxt  = 1'b0;
`endif
                    end else begin
                        w_stateNxt = S_DAT_LO;
                    end
                end
                S_DAT_LO: begin
                    w_loNxt    = rx_data;
                    w_stateNxt = S_DAT_HI;
`ifdef PMEM_LOADER_CKSUM_EN
                    w_cksumNxt = r_cksum + rx_data;
`endif
                end
                S_DAT_HI: begin
                    w_weNxt   = 1'b1;
                    w_waNxt   = r_wcnt[ADDR_W-1:0];
                    w_wdNxt   = {rx_data, r_lo};
                    w_wcntNxt = w_wcntInc;
`ifdef PMEM_LOADER_CKSUM_EN
                    w_cksumNxt = r_cksum + rx_data;
`endif
                    if (32'(w_wcntInc) == 32'(r_len)) begin
`ifdef PMEM_LOADER_CKSUM_EN
                        w_stateNxt = S_CKSUM;
`else
                        w_stateNxt = S_DONE;
                        w_doneNxt  = 1'b1;
                        w_holdNxt  = 1'b0;
`endif
                    end else begin
                        w_stateNxt = S_DAT_LO;
                    end
                end
`ifdef PMEM_LOADER_CKSUM_EN
                S_CKSUM: begin
                    if (rx_data == r_cksum) begin
                        w_stateNxt = S_DONE;
                        w_doneNxt  = 1'b1;
                        w_holdNxt  = 1'b0;
                    end else begin
                        w_stateNxt = S_ERR;
                        w_errNxt   = 1'b1;
                    end
                end
`endif
                default: begin
                    w_stateNxt = S_IDLE;
                end
            endcase
        end else if (w_inFrame && (r_tcnt == TIMEOUT - 24'd1)) begin
            w_stateNxt = S_ERR;
            w_errNxt   = 1'b1;
        end
    end

    // State and datapath registers; reset aborts any frame and releases the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_len   <= 16'd0;
            r_lo    <= 8'd0;
            r_wcnt  <= '0;
            r_tcnt  <= 24'd0;
            r_we    <= 1'b0;
            r_wa    <= '0;
            r_wd    <= 16'd0;
            r_hold  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef PMEM_LOADER_CKSUM_EN
            r_cksum <= 8'd0;
`endif
        end else begin
            r_state <= w_stateNxt;
            r_len   <= w_lenNxt;
            r_lo    <= w_loNxt;
            r_wcnt  <= w_wcntNxt;
            r_tcnt  <= w_tcntNxt;
            r_we    <= w_weNxt;
            r_wa    <= w_waNxt;
            r_wd    <= w_wdNxt;
            r_hold  <= w_holdNxt;
            r_done  <= w_doneNxt;
            r_err   <= w_errNxt;
`ifdef PMEM_LOADER_CKSUM_EN
            r_cksum <= w_cksumNxt;
`endif
        end
    end

    assign mem_we   = r_we;
    assign mem_wa   = r_wa;
    assign mem_wd   = r_wd;
    assign cpu_hold = r_hold;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_pmem_loader.sv
// Testbench for pmem_loader: randomized frames checked against a frame-level
// reference model (expected words, write timing and final status).

module tb_pmem_loader;

    localparam int          ADDR_W  = 10;
    localparam int          CAP     = 1 << ADDR_W;
    localparam logic [23:0] TIMEOUT = 24'd64;
`ifdef PMEM_LOADER_CKSUM_EN
    localparam bit HAS_CK = 1'b1;
`else
    localparam bit HAS_CK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstN;
    logic [7:0]        rxData;
    logic              rxValid;
    logic              memWe;
    logic [ADDR_W-1:0] memWa;
    logic [15:0]       memWd;
    logic              cpuHold;
    logic              done;
    logic              err;

    pmem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst_n    (rstN),
        .rx_data  (rxData),
        .rx_valid (rxValid),
        .mem_we   (memWe),
        .mem_wa   (memWa),
        .mem_wd   (memWd),
        .cpu_hold (cpuHold),
        .done     (done),
        .err      (err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int posCount = 0;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t        writeQ[$];
    wr_t        monW;
    logic [7:0] frameQ[$];
    int         cycQ[$];
    logic [15:0] wordQ[$];

    // Cycle index used to time-stamp strobes and writes.
    always @(posedge clk) posCount <= posCount + 1;

    // Record every write pulse seen on the RAM port.
    always @(negedge clk) begin
        if (memWe === 1'b1) begin
            monW.addr = int'(memWa);
            monW.data = int'(memWd);
            monW.cyc  = posCount;
            writeQ.push_back(monW);
        end
    end

    // Watchdog so the bench always terminates.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Build a frame from wordQ with the given length field and optional CK byte.
    task automatic buildFrame(input int len, input bit badCk, input bit withCk);
        int sum;
        frameQ.delete();
        frameQ.push_back(8'h55);
        frameQ.push_back(8'(len & 255));
        frameQ.push_back(8'((len >> 8) & 255));
        sum = (len & 255) + ((len >> 8) & 255);
        foreach (wordQ[i]) begin
            frameQ.push_back(wordQ[i][7:0]);
            frameQ.push_back(wordQ[i][15:8]);
            sum += int'(wordQ[i][7:0]) + int'(wordQ[i][15:8]);
        end
        if (withCk) frameQ.push_back(8'((sum + (badCk ? 1 : 0)) & 255));
    endtask

    // Send the first count bytes of frameQ back to back, then one idle clock.
    task automatic sendBytes(input int count);
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            rxValid = 1'b1;
            rxData  = frameQ[i];
        end
        @(negedge clk);
        rxValid = 1'b0;
    endtask

    // Model: expected words, their write cycles and the final status of the frame.
    task automatic predictAndCheck(input string name);
        int len;
        int n;
        int sum;
        bit expDone;
        bit expErr;
        len = int'(frameQ[1]) | (int'(frameQ[2]) << 8);
        expDone = 1'b0;
        expErr  = 1'b0;
        n = 0;
        if (len > CAP) begin
            expErr = 1'b1;
        end else begin
            n = len;
            if (HAS_CK) begin
                sum = 0;
                for (int i = 1; i <= 2 + 2 * len; i++) sum += int'(frameQ[i]);
                expDone = ((sum & 255) == int'(frameQ[3 + 2 * len]));
                expErr  = !expDone;
            end else begin
                expDone = 1'b1;
            end
        end
        checkOutput({name, "_done"}, done, expDone);
        checkOutput({name, "_err"}, err, expErr);
        checkOutput({name, "_hold"}, cpuHold, expErr);
        @(negedge clk);
        checkOutput({name, "_nwrites"}, writeQ.size(), n);
        for (int i = 0; i < n && i < writeQ.size(); i++) begin
            checkOutput({name, "_addr"}, writeQ[i].addr, i);
            checkOutput({name, "_data"}, writeQ[i].data,
                        int'(frameQ[3 + 2 * i]) | (int'(frameQ[4 + 2 * i]) << 8));
            checkOutput({name, "_wcyc"}, writeQ[i].cyc, cycQ[4 + 2 * i] + 1);
        end
    endtask

    // Drive a whole frame with random inter-byte gaps and check it against the model.
    task automatic applyStimulus(input int maxGap, input string name);
        int g;
        cycQ.delete();
        writeQ.delete();
        for (int i = 0; i < frameQ.size(); i++) begin
            @(negedge clk);
            rxValid = 1'b1;
            rxData  = frameQ[i];
            cycQ.push_back(posCount);
            if (i == 1) checkOutput({name, "_holdRise"}, cpuHold, 1);
            g = (i == frameQ.size() - 1) ? 0 : $urandom_range(maxGap, 0);
            repeat (g) begin
                @(negedge clk);
                rxValid = 1'b0;
            end
        end
        @(negedge clk);
        rxValid = 1'b0;
        predictAndCheck(name);
    endtask

    initial begin
        int len;
        rstN    = 1'b0;
        rxValid = 1'b0;
        rxData  = 8'h00;
        #12;
        checkOutput("reset_state", {memWe, memWa, memWd, cpuHold, done, err}, 32'd0);
        @(negedge clk);
        rstN = 1'b1;

        // Garbage before any sync byte.
        writeQ.delete();
        frameQ = '{8'h00, 8'hAA, 8'hFF};
        sendBytes(3);
        checkOutput("garbage_idle_flags", {cpuHold, done, err}, 32'd0);
        checkOutput("garbage_idle_nowrite", writeQ.size(), 0);

        // Two-word load.
        wordQ = '{16'h1234, 16'hABCD};
        buildFrame(2, 1'b0, HAS_CK);
        applyStimulus(0, "load2");

        // Garbage after a completed load leaves the status alone.
        writeQ.delete();
        frameQ = '{8'h00, 8'hAA, 8'hFF};
        sendBytes(3);
        checkOutput("garbage_done_flags", {cpuHold, done, err}, 32'b010);
        checkOutput("garbage_done_nowrite", writeQ.size(), 0);

`ifdef PMEM_LOADER_CKSUM_EN
        // Corrupted checksum.
        wordQ = '{16'h1234, 16'hABCD};
        buildFrame(2, 1'b1, 1'b1);
        applyStimulus(0, "badck");
`endif

        // Oversize length field.
        wordQ.delete();
        buildFrame(16'h0401, 1'b0, 1'b0);
        applyStimulus(2, "oversize");
        frameQ = '{8'h55};
        sendBytes(1);
        checkOutput("resync_flags", {cpuHold, done, err}, 32'b100);
        repeat (int'(TIMEOUT) + 4) @(negedge clk);
        checkOutput("resync_timeout_err", err, 1);

        // Random frames, including 0x55 as data and occasional bad checksums.
        for (int f = 0; f < 10; f++) begin
            wordQ.delete();
            len = $urandom_range(6, 0);
            for (int w = 0; w < len; w++) begin
                wordQ.push_back(($urandom_range(3, 0) == 0) ? 16'h5555 : 16'($urandom));
            end
            buildFrame(len, HAS_CK && ($urandom_range(3, 0) == 0), HAS_CK);
            applyStimulus(3, "rand");
        end

        // Inter-byte timeout mid-word.
        writeQ.delete();
        frameQ = '{8'h55, 8'h01, 8'h00, 8'h34};
        sendBytes(4);
        repeat (int'(TIMEOUT) - 3) @(negedge clk);
        checkOutput("timeout_early", err, 0);
        repeat (3) @(negedge clk);
        checkOutput("timeout_err", err, 1);
        checkOutput("timeout_hold", cpuHold, 1);
        checkOutput("timeout_nowrite", writeQ.size(), 0);

        // Asynchronous reset right after the first word is written.
        wordQ = '{16'h1111, 16'h2222, 16'h3333};
        buildFrame(3, 1'b0, HAS_CK);
        sendBytes(5);
        checkOutput("rst_first_we", memWe, 1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("rst_async_outputs", {memWe, memWa, memWd, cpuHold, done, err}, 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(1, "after_rst");

        // Full 1024-word image, word value equals its address.
        wordQ.delete();
        for (int w = 0; w < CAP; w++) wordQ.push_back(16'(w));
        buildFrame(CAP, 1'b0, HAS_CK);
        applyStimulus(0, "full");
        checkOutput("full_last_addr", (writeQ.size() > 0) ? writeQ[writeQ.size() - 1].addr : -1, CAP - 1);
        checkOutput("full_last_data", (writeQ.size() > 0) ? writeQ[writeQ.size() - 1].data : -1, CAP - 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
